// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - MEM-priority arbiter sharing one fixed-latency memory port between IF and MEM
//
// Purpose
//   Sequences instruction fetches (IF stage) and loads/stores (MEM stage)
//   through a single unified memory port. MEM wins contention. A read occupies
//   the port for LATENCY+1 cycles (grant plus LATENCY wait cycles, data
//   returned on the last one). A store completes in its grant cycle.
//   Per-requester stall outputs feed the pipeline hazard logic.
//
// Parameters
//   LATENCY   cycles from read strobe to port_rdata_i valid (>= 1)
//   MAX_WAIT  consecutive MEM wins tolerated while IF waits (guard build only)
//
// Optional feature
//   ARB_STARVE_GUARD_EN  when defined, a wait counter forces an IF win after
//                        MAX_WAIT MEM grants issued while IF was pending.
//                        When undefined, MEM priority is strict.
//
// Ports
//   clk_i, rst_i                      clock; synchronous active-high reset
//   if_req_i, if_addr_i               fetch request and address (held until rvalid)
//   if_gnt_o, if_rvalid_o, if_rdata_o fetch grant, data-valid pulse, data
//   mem_req_i, mem_we_i, mem_addr_i,
//   mem_wdata_i                       load/store request (held until completion)
//   mem_gnt_o, mem_rvalid_o,
//   mem_rdata_o                       data grant, load-data pulse, load data
//   port_en_o, port_we_o, port_addr_o,
//   port_wdata_o, port_rdata_i        shared memory port
//   stall_if_o, stall_mem_o           per-requester pipeline stalls

module mem_port_arbiter #(
    parameter int unsigned LATENCY  = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,

    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic        mem_gnt_o,
    output logic        mem_rvalid_o,
    output logic [31:0] mem_rdata_o,

    output logic        port_en_o,
    output logic        port_we_o,
    output logic [31:0] port_addr_o,
    output logic [31:0] port_wdata_o,
    input  logic [31:0] port_rdata_i,

    output logic        stall_if_o,
    output logic        stall_mem_o
);

    // Elaboration-time parameter sanity.
    if (LATENCY < 1) begin : g_bad_latency
        $error("mem_port_arbiter: LATENCY must be at least 1");
    end
    if (MAX_WAIT < 1) begin : g_bad_max_wait
        $error("mem_port_arbiter: MAX_WAIT must be at least 1");
    end

    localparam int unsigned      CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2
    } state_e;

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic             rst_dly_q, rst_dly_d;

    logic blank;      // all outputs held at 0 (reset cycle and the one after)
    logic arb_idle;   // arbitration allowed this cycle
    logic force_if;   // starvation guard overrides MEM priority
    logic mem_win;
    logic if_win;

    // Outputs stay quiet for one extra cycle after reset so a request that was
    // already asserted during reset is not granted in the recovery cycle.
    assign rst_dly_d = rst_i;
    assign blank     = rst_i | rst_dly_q;
    assign arb_idle  = (state_q == IDLE) && !blank;
    assign mem_win   = arb_idle && mem_req_i && !force_if;
    assign if_win    = arb_idle && if_req_i && !mem_win;

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned       WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    // The counter cannot pass WAIT_MAX: once it gets there with IF pending,
    // IF wins the next arbitration and no MEM grant can increment it.
    assign force_if = if_req_i && (wait_cnt_q == WAIT_MAX);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (mem_win && if_req_i) begin
            wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end else if (if_win || ((state_q == IDLE) && !if_req_i)) begin
            wait_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        if_gnt_o     = if_win;
        mem_gnt_o    = mem_win;
        if_rvalid_o  = 1'b0;
        mem_rvalid_o = 1'b0;
        port_en_o    = if_win | mem_win;
        port_we_o    = mem_win & mem_we_i;
        port_addr_o  = mem_win ? mem_addr_i : (if_win ? if_addr_i : 32'd0);
        port_wdata_o = mem_win ? mem_wdata_i : 32'd0;

        unique case (state_q)
            IDLE: begin
                // Stores finish in the grant cycle, so only reads leave IDLE.
                if (mem_win && !mem_we_i) begin
                    state_d   = BUSY_MEM;
                    lat_cnt_d = CNT_LOAD;
                end else if (if_win) begin
                    state_d   = BUSY_IF;
                    lat_cnt_d = CNT_LOAD;
                end
            end
            BUSY_IF: begin
                if (lat_cnt_q == '0) begin
                    if_rvalid_o = !blank;
                    state_d     = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - CNT_ONE;
                end
            end
            BUSY_MEM: begin
                if (lat_cnt_q == '0) begin
                    mem_rvalid_o = !blank;
                    state_d      = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d   = IDLE;
                lat_cnt_d = '0;
            end
        endcase

        if_rdata_o  = if_rvalid_o  ? port_rdata_i : 32'd0;
        mem_rdata_o = mem_rvalid_o ? port_rdata_i : 32'd0;

        stall_if_o  = !blank && if_req_i && !if_rvalid_o;
        stall_mem_o = !blank && mem_req_i && !((mem_win && mem_we_i) || mem_rvalid_o);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        rst_dly_q <= rst_dly_d;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int LAT    = 2;
    localparam int MAXW   = 4;
    localparam int N_RAND = 3000;

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk_i        = 1'b0;
    logic        rst_i        = 1'b1;
    logic        if_req_i     = 1'b0;
    logic [31:0] if_addr_i    = 32'd0;
    logic        mem_req_i    = 1'b0;
    logic        mem_we_i     = 1'b0;
    logic [31:0] mem_addr_i   = 32'd0;
    logic [31:0] mem_wdata_i  = 32'd0;
    logic [31:0] port_rdata_i = 32'd0;

    logic        if_gnt_o, if_rvalid_o, mem_gnt_o, mem_rvalid_o;
    logic [31:0] if_rdata_o, mem_rdata_o;
    logic        port_en_o, port_we_o;
    logic [31:0] port_addr_o, port_wdata_o;
    logic        stall_if_o, stall_mem_o;

    mem_port_arbiter #(.LATENCY(LAT), .MAX_WAIT(MAXW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i),
        .mem_gnt_o(mem_gnt_o), .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o),
        .port_en_o(port_en_o), .port_we_o(port_we_o), .port_addr_o(port_addr_o),
        .port_wdata_o(port_wdata_o), .port_rdata_i(port_rdata_i),
        .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Memory contents: every word starts as a hash of its address.
    function automatic logic [31:0] ram_init(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    logic [31:0] ram     [logic [31:0]];   // environment RAM behind the port
    logic [31:0] ref_mem [logic [31:0]];   // reference view in MEM program order
    logic [31:0] rd_due  [int];            // read data scheduled per cycle
    logic [31:0] exp_if_q[$];
    logic [31:0] exp_mem_q[$];

    // Reference model state
    bit busy = 1'b0, busy_if = 1'b0, rst_prev = 1'b1;
    int due = 0, wait_cnt = 0;
    bit if_done = 1'b0, mem_done = 1'b0;
    int first_if_gnt = -1, first_mem_gnt = -1, first_if_rv = -1, first_mem_rv = -1;
    int if_gnt_cnt = 0, mem_rv_cnt = 0;

    logic        blank, idle_start, force_if;
    logic        exp_if_g, exp_mem_g, exp_if_rv, exp_mem_rv;
    logic [31:0] exp_addr, exp_wdata, rd_word;

    // Monitor: evaluates the arbitration rules once per cycle and pops the
    // scoreboard whenever the DUT presents read data.
    always @(negedge clk_i) begin
        blank    = rst_i || rst_prev;
        if_done  = 1'b0;
        mem_done = 1'b0;
        if (blank) begin
            check("reset_quiet", |{if_gnt_o, if_rvalid_o, if_rdata_o, mem_gnt_o, mem_rvalid_o,
                                   mem_rdata_o, port_en_o, port_we_o, port_addr_o,
                                   port_wdata_o, stall_if_o, stall_mem_o}, 0);
            busy     = 1'b0;
            wait_cnt = 0;
        end else begin
            idle_start = !busy;
            force_if   = GUARD && if_req_i && (wait_cnt == MAXW);
            exp_mem_g  = idle_start && mem_req_i && !force_if;
            exp_if_g   = idle_start && if_req_i && !exp_mem_g;
            exp_if_rv  = busy && busy_if && (cyc == due);
            exp_mem_rv = busy && !busy_if && (cyc == due);
            exp_addr   = exp_mem_g ? mem_addr_i : (exp_if_g ? if_addr_i : 32'd0);
            exp_wdata  = exp_mem_g ? mem_wdata_i : 32'd0;

            check("if_gnt",     if_gnt_o,     exp_if_g);
            check("mem_gnt",    mem_gnt_o,    exp_mem_g);
            check("if_rvalid",  if_rvalid_o,  exp_if_rv);
            check("mem_rvalid", mem_rvalid_o, exp_mem_rv);
            check("port_en",    port_en_o,    exp_if_g || exp_mem_g);
            check("port_we",    port_we_o,    exp_mem_g && mem_we_i);
            check("port_addr",  port_addr_o,  exp_addr);
            check("port_wdata", port_wdata_o, exp_wdata);
            check("stall_if",   stall_if_o,   if_req_i && !exp_if_rv);
            check("stall_mem",  stall_mem_o,  mem_req_i && !((exp_mem_g && mem_we_i) || exp_mem_rv));

            if (!if_rvalid_o) begin
                check("if_rdata_idle", if_rdata_o, 0);
            end else begin
                check("if_sb_pending", exp_if_q.size() != 0, 1);
                if (exp_if_q.size() != 0) check("if_rdata", if_rdata_o, exp_if_q.pop_front());
            end
            if (!mem_rvalid_o) begin
                check("mem_rdata_idle", mem_rdata_o, 0);
            end else begin
                check("mem_sb_pending", exp_mem_q.size() != 0, 1);
                if (exp_mem_q.size() != 0) check("mem_rdata", mem_rdata_o, exp_mem_q.pop_front());
            end

            if (busy && cyc == due) busy = 1'b0;
            if (exp_if_g || (exp_mem_g && !mem_we_i)) begin
                busy    = 1'b1;
                busy_if = exp_if_g;
                due     = cyc + LAT;
            end
            if (exp_mem_g && if_req_i)          wait_cnt++;
            else if (exp_if_g)                  wait_cnt = 0;
            else if (idle_start && !if_req_i)   wait_cnt = 0;

            if_done  = if_rvalid_o;
            mem_done = mem_rvalid_o || (mem_gnt_o && mem_we_i);
            if (if_gnt_o) begin
                if_gnt_cnt++;
                if (first_if_gnt < 0) first_if_gnt = cyc;
            end
            if (mem_gnt_o && first_mem_gnt < 0) first_mem_gnt = cyc;
            if (if_rvalid_o && first_if_rv < 0) first_if_rv = cyc;
            if (mem_rvalid_o) begin
                mem_rv_cnt++;
                if (first_mem_rv < 0) first_mem_rv = cyc;
            end
        end

        if (port_en_o) begin
            if (port_we_o) begin
                ram[port_addr_o] = port_wdata_o;
            end else begin
                rd_word = ram.exists(port_addr_o) ? ram[port_addr_o] : ram_init(port_addr_o);
                rd_due[cyc + LAT] = rd_word;
            end
        end
        rst_prev = rst_i;
    end

    // Memory read-data bus: scheduled data on its due cycle, junk otherwise.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (rd_due.exists(cyc)) begin
                port_rdata_i = rd_due[cyc];
                rd_due.delete(cyc);
            end else begin
                port_rdata_i = $urandom;
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
        if (if_req_i && if_done)   if_req_i  = 1'b0;
        if (mem_req_i && mem_done) mem_req_i = 1'b0;
    endtask

    task automatic arm();
        first_if_gnt = -1; first_mem_gnt = -1; first_if_rv = -1; first_mem_rv = -1;
        if_gnt_cnt = 0; mem_rv_cnt = 0;
    endtask

    task automatic issue_if(input logic [31:0] a);
        if_addr_i = a;
        if_req_i  = 1'b1;
        exp_if_q.push_back(ram_init(a));
    endtask

    task automatic issue_mem(input logic we, input logic [31:0] a, input logic [31:0] d);
        mem_we_i    = we;
        mem_addr_i  = a;
        mem_wdata_i = d;
        mem_req_i   = 1'b1;
        if (we) ref_mem[a] = d;
        else    exp_mem_q.push_back(ref_mem.exists(a) ? ref_mem[a] : ram_init(a));
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (if_req_i || mem_req_i); i++) step();
        step();
        check("drain_idle", {if_req_i, mem_req_i}, 0);
    endtask

    int s;
    int if_left, mem_left;

    initial begin
        step(); step(); step();
        rst_i = 1'b0;
        step();

        // IF read alone
        arm(); s = cyc;
        issue_if(32'h0000_0100);
        drain();
        check("if_alone_gnt_cycle", first_if_gnt - s, 0);
        check("if_alone_rvalid_cycle", first_if_rv - s, LAT);

        // Simultaneous reads: MEM first, IF right after MEM's data returns
        arm(); s = cyc;
        issue_mem(1'b0, 32'h8000_0010, $urandom);
        issue_if(32'h0000_0104);
        drain();
        check("both_mem_gnt_cycle", first_mem_gnt - s, 0);
        check("both_mem_rvalid_cycle", first_mem_rv - s, LAT);
        check("both_if_gnt_cycle", first_if_gnt - s, LAT + 1);
        check("both_if_rvalid_cycle", first_if_rv - s, 2 * LAT + 1);

        // Store with IF pending
        arm(); s = cyc;
        issue_mem(1'b1, 32'h8000_0040, 32'h55);
        issue_if(32'h0000_0108);
        drain();
        check("store_mem_gnt_cycle", first_mem_gnt - s, 0);
        check("store_no_mem_rvalid", mem_rv_cnt, 0);
        check("store_if_gnt_cycle", first_if_gnt - s, 1);

        // Load back what the store wrote
        issue_mem(1'b0, 32'h8000_0040, $urandom);
        drain();

        // Starvation: IF held while MEM issues back-to-back stores
        step();
        arm(); s = cyc;
        issue_if(32'h0000_0200);
        issue_mem(1'b1, 32'h8000_0000, $urandom);
        for (int i = 0; i < 50; i++) begin
            step();
            if (!mem_req_i) issue_mem(1'b1, 32'h8000_0000 + 32'((i % 16) * 4), $urandom);
        end
`ifdef ARB_STARVE_GUARD_EN
        check("starve_if_gnt_cycle", first_if_gnt - s, MAXW);
`else
        check("starve_if_gnt_count", if_gnt_cnt, 0);
`endif
        drain();

        // Reset one cycle into an IF read: read discarded, re-granted after recovery
        arm(); s = cyc;
        issue_if(32'h0000_0300);
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        arm();
        drain();
        check("rst_regrant_cycle", first_if_gnt - s, 3);
        check("rst_rvalid_cycle", first_if_rv - s, 3 + LAT);

        // Randomized traffic with occasional resets
        if_left  = 400;
        mem_left = 400;
        for (int i = 0; i < N_RAND; i++) begin
            step();
            if (rst_i) rst_i = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst_i = 1'b1;
            if (!if_req_i && if_left > 0 && $urandom_range(0, 2) == 0) begin
                issue_if(32'h0000_1000 + ($urandom_range(0, 255) << 2));
                if_left--;
            end else if (!if_req_i) begin
                if_addr_i = $urandom;
            end
            if (!mem_req_i && mem_left > 0 && $urandom_range(0, 1) == 0) begin
                issue_mem(1'($urandom_range(0, 1)), 32'h8000_0000 + ($urandom_range(0, 15) << 2),
                          $urandom);
                mem_left--;
            end else if (!mem_req_i) begin
                mem_addr_i  = $urandom;
                mem_wdata_i = $urandom;
                mem_we_i    = 1'($urandom_range(0, 1));
            end
        end
        rst_i = 1'b0;
        drain();

        check("if_sb_empty", exp_if_q.size(), 0);
        check("mem_sb_empty", exp_mem_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-ported, fixed-latency unified memory between the pipelined core's instruction-fetch requester (IF stage) and its load/store requester (MEM stage). It sequences each access through the shared port, returns read data to the winning requester, and raises per-requester stall signals. The hazard logic folds these stalls into PC/IF-ID enables and pipeline freezes. MEM has priority; an optional starvation guard bounds how long IF can wait.

## Interface
- LATENCY, 2, cycles from port read issue to `port_rdata_i` valid; must be ≥1
- MAX_WAIT, 4, consecutive MEM wins while IF is pending before IF is forced (guard only)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- if_req_i  in  1  instruction read request; held with addr until `if_rvalid_o`
- if_addr_i  in  32  fetch address
- if_gnt_o  out  1  IF access issued this cycle
- if_rvalid_o  out  1  one-cycle pulse, `if_rdata_o` valid
- if_rdata_o  out  32  fetch data; 0 when `if_rvalid_o`=0
- mem_req_i  in  1  data request; held until completion
- mem_we_i  in  1  1=store, 0=load
- mem_addr_i  in  32  data address
- mem_wdata_i  in  32  store data
- mem_gnt_o  out  1  MEM access issued this cycle
- mem_rvalid_o  out  1  one-cycle load-data pulse; never for stores
- mem_rdata_o  out  32  load data; 0 when `mem_rvalid_o`=0
- port_en_o  out  1  memory access strobe
- port_we_o  out  1  memory write enable
- port_addr_o  out  32  memory address
- port_wdata_o  out  32  memory write data
- port_rdata_i  in  32  memory read data, LATENCY cycles after a read strobe
- stall_if_o  out  1  `if_req_i` & ~`if_rvalid_o`
- stall_mem_o  out  1  `mem_req_i` & ~(store granted this cycle | `mem_rvalid_o`)

## Operation
- States: IDLE, BUSY_IF, BUSY_MEM. A latency counter of width $clog2(LATENCY+1) is active in the BUSY states.
- IDLE with no request: all port outputs are 0.
- IDLE grant (combinational, same cycle as request):
  - Winner is MEM if `mem_req_i`, else IF; the guard can override (see Configuration).
  - Assert the winner's gnt and `port_en_o`; drive the winner's addr on `port_addr_o`.
  - `port_we_o` = `mem_we_i` when MEM wins, else 0; `port_wdata_o` = `mem_wdata_i` when MEM wins, else 0.
- Store grant: completes in the grant cycle; the state stays IDLE, so the next grant is possible on the next cycle.
- Read grant: go to BUSY_x with counter = LATENCY−1.
  - BUSY_x: decrement each cycle.
  - At 0, pulse x_rvalid_o with x_rdata_o = `port_rdata_i`, then return to IDLE.
  - No grants are issued in BUSY states.
- If a requester drops req mid-read, the rvalid pulse still occurs (protocol violation, no error).
- Only one gnt or rvalid per requester per transaction; `if_gnt_o` and `mem_gnt_o` are never both 1.
- `port_addr_o`/`port_wdata_o` are 0 whenever `port_en_o`=0.

## Timing
- Reset: state IDLE, counters 0; every output 0 in the cycle `rst_i` is high and the cycle after. Ignore requests while `rst_i`=1.
- Reset mid-read: the transaction is discarded and no rvalid is ever produced for it.
- Read latency: grant at cycle T, rvalid at T+LATENCY; earliest next grant at T+LATENCY+1. Read throughput is 1 per LATENCY+1 cycles.
- Store latency: grant at T, completion at T; next grant at T+1.
- Simultaneous requests in IDLE are resolved by priority in that cycle; the loser's stall stays 1.
- Stalls are combinational from req, state and counter.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - A wait counter of width $clog2(MAX_WAIT+1), reset to 0, increments on every MEM grant issued while `if_req_i`=1.
  - It clears on an IF grant, or when `if_req_i`=0 in IDLE.
  - When the counter equals MAX_WAIT, IF wins the next IDLE arbitration even if `mem_req_i`=1.
- Undefined: strict MEM priority; no wait counter exists; IF can starve indefinitely.

## Test plan
- IF read alone, LATENCY=2: `if_req_i`=1, addr 0x100 at cycle 0 → `if_gnt_o`=1, `port_en_o`=1, `port_addr_o`=0x100 at cycle 0; `if_rvalid_o`=1 with `if_rdata_o`=`port_rdata_i` (0xDEADBEEF) at cycle 2; `stall_if_o`=1 at cycles 0–1 and 0 at cycle 2.
- Both reads request at cycle 0 → `mem_gnt_o` at 0, `mem_rvalid_o` at 2, `if_gnt_o` at 3, `if_rvalid_o` at 5; `stall_if_o`=1 at cycles 0–4.
- Store: `mem_we_i`=1, addr 0x40, wdata 0x55 with IF pending at cycle 0 → `port_we_o`=1, `port_wdata_o`=0x55 at 0, `stall_mem_o`=0 at 0, no `mem_rvalid_o`, `if_gnt_o` at 1.
- Starvation, MAX_WAIT=4, both reqs held with stores: macro defined → four MEM grants (cycles 0–3), `if_gnt_o` at cycle 4; macro undefined → `if_gnt_o` never asserts over 50 cycles.
- Reset at cycle 1 of a LATENCY=3 IF read → all outputs 0 at cycles 1–2, no `if_rvalid_o` at cycle 3, IDLE grant of a new request at cycle 3.
